// File: rtl/data_mem_io_pkg.sv
// Shared constants for the data-memory / memory-mapped I/O stage:
// I/O region tag, I/O register byte addresses, ready-bit indices and field widths.
`timescale 1ns/1ps
package data_mem_io_pkg;

  // addr[31:28] equal to this tag selects the I/O region instead of RAM.
  localparam logic [3:0] IO_TAG = 4'hF;

  // Word-aligned I/O register addresses.
  localparam logic [31:0] ADDR_HEX   = 32'hF000_0000;
  localparam logic [31:0] ADDR_LEDR  = 32'hF000_0004;
  localparam logic [31:0] ADDR_KDATA = 32'hF000_0010;
  localparam logic [31:0] ADDR_KCTRL = 32'hF000_0014;
  localparam logic [31:0] ADDR_SDATA = 32'hF000_0018;
  localparam logic [31:0] ADDR_TCNT  = 32'hF000_0020;
  localparam logic [31:0] ADDR_TLIM  = 32'hF000_0024;
  localparam logic [31:0] ADDR_TCTL  = 32'hF000_0028;

  // Sticky ready-bit positions inside KCTRL and TCTL.
  localparam int unsigned KCTRL_READY_BIT = 0;
  localparam int unsigned TCTL_READY_BIT  = 0;

  // Board I/O field widths.
  localparam int unsigned HEX_W  = 16;
  localparam int unsigned LEDR_W = 10;
  localparam int unsigned KEY_W  = 4;
  localparam int unsigned SW_W   = 10;

endpackage

// File: rtl/data_mem_io_debounce.sv
// io_debounce: 2-flop synchronizer followed by a group debouncer.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   raw          - asynchronous input vector
//   stable       - debounced value (registered)
//   accept_c     - combinational; high in the cycle whose edge loads a new stable value
`timescale 1ns/1ps
module io_debounce #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable,
  output logic             accept_c
);

  // Counter must hold DEBOUNCE_CYCLES-1; keep at least one bit.
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CNT_W-1:0] cnt;

  // The synced value has differed long enough; load it on this edge.
  assign accept_c = (sync2 != stable) && (cnt == CNT_LAST);

  // Synchronizer, stability counter and debounced value.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      cnt    <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (accept_c) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/data_mem_io.sv
// data_mem_io: data RAM plus memory-mapped board I/O (HEX, LEDR, keys,
// switches, cycle timer) for the single-cycle processor.
// Ports:
//   clk, reset   - processor clock, synchronous active-high reset
//   lock         - PLL lock; timer counts only while high
//   wrtEn        - qualified store enable
//   addr, wData  - byte address and store data
//   rData        - combinational load data
//   key, sw      - asynchronous push buttons / slide switches
//   ledr, hex    - registered LED and HEX output values
`timescale 1ns/1ps
module data_mem_io
  import data_mem_io_pkg::*;
#(
  parameter int unsigned DBITS           = 32,
  parameter int unsigned MEM_WORDS       = 2048,
  parameter int unsigned DEBOUNCE_CYCLES = 10,
  parameter string       MEM_INIT        = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lock,
  input  logic              wrtEn,
  input  logic [DBITS-1:0]  addr,
  input  logic [DBITS-1:0]  wData,
  output logic [DBITS-1:0]  rData,
  input  logic [KEY_W-1:0]  key,
  input  logic [SW_W-1:0]   sw,
  output logic [LEDR_W-1:0] ledr,
  output logic [HEX_W-1:0]  hex
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);

  logic [DBITS-1:0] mem [MEM_WORDS];

  // RAM image, when given, is attached by the FPGA memory-initialization flow.
  if (MEM_INIT != "") begin : gMemInit
  end

  logic [IDX_W-1:0] wordIdx;
  logic             isIo;
  logic             ioWr;
  logic             wrHex, wrLedr, wrKctrl, wrTcnt, wrTlim, wrTctl;

  logic [KEY_W-1:0] keyStable;
  logic             keyAccept;
  logic [SW_W-1:0]  swStable;
  logic             swAcceptUnused;

  logic [DBITS-1:0] tcnt;
  logic [DBITS-1:0] tlim;
  logic             kReady;
  logic             tReady;
  logic             timerWrap;

  // Word index wraps: address bits above the RAM depth alias.
  assign wordIdx = addr[IDX_W+1:2];
  assign isIo    = (addr[DBITS-1 -: 4] == IO_TAG);
  assign ioWr    = wrtEn && isIo;

  assign wrHex   = ioWr && (addr == DBITS'(ADDR_HEX));
  assign wrLedr  = ioWr && (addr == DBITS'(ADDR_LEDR));
  assign wrKctrl = ioWr && (addr == DBITS'(ADDR_KCTRL));
  assign wrTcnt  = ioWr && (addr == DBITS'(ADDR_TCNT));
  assign wrTlim  = ioWr && (addr == DBITS'(ADDR_TLIM));
  assign wrTctl  = ioWr && (addr == DBITS'(ADDR_TCTL));

  // A CPU write to TCNT/TLIM suppresses the wrap and its ready event.
  assign timerWrap = lock && !wrTcnt && !wrTlim &&
                     (tlim != '0) && (tcnt == tlim - DBITS'(1));

  io_debounce #(.WIDTH(KEY_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uKeyDebounce (
    .clk      (clk),
    .reset    (reset),
    .raw      (key),
    .stable   (keyStable),
    .accept_c (keyAccept)
  );

  io_debounce #(.WIDTH(SW_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uSwDebounce (
    .clk      (clk),
    .reset    (reset),
    .raw      (sw),
    .stable   (swStable),
    .accept_c (swAcceptUnused)
  );

  // Data RAM write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (wrtEn && !isIo) begin
      mem[wordIdx] <= wData;
    end
  end

  // I/O registers and timer.
  always_ff @(posedge clk) begin
    if (reset) begin
      hex    <= '0;
      ledr   <= '0;
      tcnt   <= '0;
      tlim   <= '0;
      kReady <= 1'b0;
      tReady <= 1'b0;
    end else begin
      if (wrHex)  hex  <= wData[HEX_W-1:0];
      if (wrLedr) ledr <= wData[LEDR_W-1:0];

      if (wrTlim) begin
        tlim <= wData;
        tcnt <= '0;
      end else if (wrTcnt) begin
        tcnt <= wData;
      end else if (timerWrap) begin
        tcnt <= '0;
      end else if (lock) begin
        tcnt <= tcnt + DBITS'(1);
      end

      // Hardware set wins over a same-cycle CPU clear.
      if (keyAccept) begin
        kReady <= 1'b1;
      end else if (wrKctrl && !wData[KCTRL_READY_BIT]) begin
        kReady <= 1'b0;
      end

      if (timerWrap) begin
        tReady <= 1'b1;
      end else if (wrTctl && !wData[TCTL_READY_BIT]) begin
        tReady <= 1'b0;
      end
    end
  end

  // Load mux; unmapped I/O and unused high bits read 0.
  always_comb begin
    rData = '0;
    if (isIo) begin
      case (addr)
        DBITS'(ADDR_HEX):   rData = DBITS'(hex);
        DBITS'(ADDR_LEDR):  rData = DBITS'(ledr);
        DBITS'(ADDR_KDATA): rData = DBITS'(keyStable);
        DBITS'(ADDR_KCTRL): rData = DBITS'(kReady) << KCTRL_READY_BIT;
        DBITS'(ADDR_SDATA): rData = DBITS'(swStable);
        DBITS'(ADDR_TCNT):  rData = tcnt;
        DBITS'(ADDR_TLIM):  rData = tlim;
        DBITS'(ADDR_TCTL):  rData = DBITS'(tReady) << TCTL_READY_BIT;
        default:            rData = '0;
      endcase
    end else begin
      rData = mem[wordIdx];
    end
  end

endmodule

// File: tb/tb_data_mem_io.sv
// Self-checking bench for data_mem_io: table of store/load vectors, then
// hand-written sequences for debounce, timer and reset corner cases.
`timescale 1ns/1ps
module tb_data_mem_io;

  logic        clk;
  logic        reset;
  logic        lock;
  logic        wrtEn;
  logic [31:0] addr;
  logic [31:0] wData;
  logic [31:0] rData;
  logic [3:0]  key;
  logic [9:0]  sw;
  logic [9:0]  ledr;
  logic [15:0] hex;

  localparam logic [31:0] A_HEX   = 32'hF000_0000;
  localparam logic [31:0] A_LEDR  = 32'hF000_0004;
  localparam logic [31:0] A_KDATA = 32'hF000_0010;
  localparam logic [31:0] A_KCTRL = 32'hF000_0014;
  localparam logic [31:0] A_SDATA = 32'hF000_0018;
  localparam logic [31:0] A_TCNT  = 32'hF000_0020;
  localparam logic [31:0] A_TLIM  = 32'hF000_0024;
  localparam logic [31:0] A_TCTL  = 32'hF000_0028;

  int nCmp = 0;
  int nBad = 0;

  data_mem_io #(
    .DBITS(32), .MEM_WORDS(2048), .DEBOUNCE_CYCLES(10), .MEM_INIT("")
  ) dut (
    .clk   (clk),
    .reset (reset),
    .lock  (lock),
    .wrtEn (wrtEn),
    .addr  (addr),
    .wData (wData),
    .rData (rData),
    .key   (key),
    .sw    (sw),
    .ledr  (ledr),
    .hex   (hex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          isWr;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wData = d;
    wrtEn = 1'b1;
    step();
    wrtEn = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    wrtEn = 1'b0;
    addr  = a;
    #1;
    chk(name, rData, exp);
  endtask

  initial begin
    int tcntSeq[5] = '{1, 2, 3, 4, 0};

    reset = 1'b1; lock = 1'b0; wrtEn = 1'b0;
    addr = '0; wData = '0; key = '0; sw = '0;
    step(); step();
    reset = 1'b0;

    // Reset state
    chk("rst_ledr", 32'(ledr), 32'h0);
    chk("rst_hex", 32'(hex), 32'h0);
    rd(A_TCNT,  32'h0, "rst_tcnt");
    rd(A_TLIM,  32'h0, "rst_tlim");
    rd(A_KCTRL, 32'h0, "rst_kctrl");
    rd(A_TCTL,  32'h0, "rst_tctl");
    rd(A_KDATA, 32'h0, "rst_kdata");
    rd(A_SDATA, 32'h0, "rst_sdata");

    // Store/load vectors (lock low, inputs idle)
    vecs.push_back('{1'b1, 32'h0000_0100, 32'h1234_5678, 32'h0,         "st_ram"});
    vecs.push_back('{1'b0, 32'h0000_0100, 32'h0,         32'h1234_5678, "ld_ram"});
    vecs.push_back('{1'b0, 32'h0000_2100, 32'h0,         32'h1234_5678, "ld_alias"});
    vecs.push_back('{1'b1, 32'h0000_0104, 32'hA5A5_0001, 32'h0,         "st_ram2"});
    vecs.push_back('{1'b0, 32'h0000_0107, 32'h0,         32'hA5A5_0001, "ld_byteoff"});
    vecs.push_back('{1'b0, 32'h0000_0100, 32'h0,         32'h1234_5678, "ld_neighbour"});
    vecs.push_back('{1'b1, 32'hF000_0100, 32'hDEAD_BEEF, 32'h0,         "st_io_unmapped"});
    vecs.push_back('{1'b0, 32'h0000_0100, 32'h0,         32'h1234_5678, "ld_ram_untouched"});
    vecs.push_back('{1'b0, 32'hF000_0100, 32'h0,         32'h0,         "ld_io_unmapped"});
    vecs.push_back('{1'b1, A_LEDR,        32'hFFFF_FFFF, 32'h0,         "st_ledr"});
    vecs.push_back('{1'b0, A_LEDR,        32'h0,         32'h0000_03FF, "ld_ledr"});
    vecs.push_back('{1'b1, A_HEX,         32'h1234_BEEF, 32'h0,         "st_hex"});
    vecs.push_back('{1'b0, A_HEX,         32'h0,         32'h0000_BEEF, "ld_hex"});
    vecs.push_back('{1'b0, 32'hF000_0030, 32'h0,         32'h0,         "ld_f0000030"});
    vecs.push_back('{1'b1, A_KDATA,       32'hFFFF_FFFF, 32'h0,         "st_kdata"});
    vecs.push_back('{1'b0, A_KDATA,       32'h0,         32'h0,         "ld_kdata_ro"});
    vecs.push_back('{1'b1, A_SDATA,       32'h0000_03FF, 32'h0,         "st_sdata"});
    vecs.push_back('{1'b0, A_SDATA,       32'h0,         32'h0,         "ld_sdata_ro"});

    foreach (vecs[i]) begin
      if (vecs[i].isWr) wr(vecs[i].a, vecs[i].d);
      else              rd(vecs[i].a, vecs[i].exp, vecs[i].name);
    end

    chk("port_ledr", 32'(ledr), 32'h3FF);
    chk("port_hex",  32'(hex),  32'hBEEF);
    reset = 1'b1; step(); reset = 1'b0;
    chk("rst2_ledr", 32'(ledr), 32'h0);
    chk("rst2_hex",  32'(hex),  32'h0);

    // Short key pulse is rejected
    key = 4'b0001;
    repeat (5) step();
    key = 4'b0000;
    repeat (20) step();
    rd(A_KDATA, 32'h0, "glitch_kdata");
    rd(A_KCTRL, 32'h0, "glitch_kctrl");

    // Held key accepted on the 12th edge
    key = 4'b0001;
    repeat (11) step();
    rd(A_KDATA, 32'h0, "hold11_kdata");
    rd(A_KCTRL, 32'h0, "hold11_kctrl");
    step();
    rd(A_KDATA, 32'h1, "hold12_kdata");
    rd(A_KCTRL, 32'h1, "hold12_kctrl");
    wr(A_KCTRL, 32'h0);
    rd(A_KCTRL, 32'h0, "kctrl_clear");

    // Release is also a change
    key = 4'b0000;
    repeat (12) step();
    rd(A_KDATA, 32'h0, "release_kdata");
    rd(A_KCTRL, 32'h1, "release_kctrl");
    wr(A_KCTRL, 32'h0);

    // Switches debounce independently and do not touch KCTRL
    sw = 10'h2AA;
    repeat (11) step();
    rd(A_SDATA, 32'h0, "sw11_sdata");
    step();
    rd(A_SDATA, 32'h2AA, "sw12_sdata");
    rd(A_KCTRL, 32'h0, "sw_kctrl");

    // Timer with TLIM=5
    wr(A_TLIM, 32'd5);
    rd(A_TLIM, 32'd5, "tlim_rd");
    rd(A_TCNT, 32'd0, "tcnt_start");
    lock = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      rd(A_TCNT, 32'(tcntSeq[i]), $sformatf("tcnt_seq%0d", i));
      if (tcntSeq[i] == 4) rd(A_TCTL, 32'h0, "tctl_prewrap");
    end
    rd(A_TCTL, 32'h1, "tctl_wrap");
    step(); step();
    lock = 1'b0;
    repeat (3) step();
    rd(A_TCNT, 32'd2, "tcnt_hold");
    wr(A_TCTL, 32'h0);
    rd(A_TCTL, 32'h0, "tctl_clear");

    // CPU clear in the wrap cycle loses to the hardware set
    lock = 1'b1;
    step(); step();
    rd(A_TCNT, 32'd4, "tcnt_before_clash");
    wr(A_TCTL, 32'h0);
    rd(A_TCTL, 32'h1, "tctl_clash");
    rd(A_TCNT, 32'd0, "tcnt_clash_wrap");

    // CPU write to TCNT beats the increment
    wr(A_TCNT, 32'd100);
    rd(A_TCNT, 32'd100, "tcnt_write");
    step();
    rd(A_TCNT, 32'd101, "tcnt_after_write");

    // TLIM=0 free-runs with 32-bit wrap and no ready event
    wr(A_TCTL, 32'h0);
    wr(A_TLIM, 32'h0);
    wr(A_TCNT, 32'hFFFF_FFFF);
    rd(A_TCNT, 32'hFFFF_FFFF, "tcnt_max");
    step();
    rd(A_TCNT, 32'h0, "tcnt_freewrap");
    rd(A_TCTL, 32'h0, "tctl_free_noready");

    // Reset mid-count; first count on the edge after release
    repeat (3) step();
    reset = 1'b1; step(); reset = 1'b0;
    rd(A_TCNT, 32'd0, "tcnt_rst");
    step();
    rd(A_TCNT, 32'd1, "tcnt_after_rst");

    // Reset mid-debounce restarts the whole input path
    lock = 1'b0;
    key = 4'b1000;
    repeat (6) step();
    reset = 1'b1; step(); reset = 1'b0;
    repeat (11) step();
    rd(A_KDATA, 32'h0, "rstdeb11_kdata");
    step();
    rd(A_KDATA, 32'h8, "rstdeb12_kdata");
    rd(A_KCTRL, 32'h1, "rstdeb12_kctrl");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/data_mem_io.md
# data_mem_io

Data-memory and memory-mapped I/O stage for the single-cycle processor. Sits directly downstream of the processor controller. Consumes the ALU address, the store data and the qualified memory write enable. Returns the load word that the controller routes to the register-file write-back mux. Owns the data RAM, the board LED/HEX output registers, debounced key and switch inputs, and a cycle timer.

## Interface
Parameters:
- DBITS, 32, data and address width.
- MEM_WORDS, 2048, data RAM depth in words (power of two).
- DEBOUNCE_CYCLES, 10, cycles an input must be stable before it is accepted.
- MEM_INIT, "", optional RAM init file.

Ports:
- clk  in  1  processor clock.
- reset  in  1  synchronous, active-high.
- lock  in  1  PLL lock; the timer counts only while high.
- wrtEn  in  1  memory write enable, already qualified by lock and the write phase upstream.
- addr  in  DBITS  byte address (ALU output).
- wData  in  DBITS  store data.
- rData  out  DBITS  load data, combinational from addr.
- key  in  4  push buttons, active-high, asynchronous to clk.
- sw  in  10  slide switches, asynchronous.
- ledr  out  10  LED register.
- hex  out  16  four-digit HEX value; digit decode is done elsewhere.

## Operation
- Address decode: addr[31:28]==4'hF selects I/O; anything else selects RAM.
- RAM word index is addr[log2(MEM_WORDS)+1:2]. Higher bits alias (wrap). Byte offset bits are ignored.
- I/O map (word-aligned):
  - F0000000 HEX, R/W, bits [15:0].
  - F0000004 LEDR, R/W, bits [9:0].
  - F0000010 KDATA, RO, debounced keys.
  - F0000014 KCTRL, bit0 = key-change ready (sticky). Writing bit0=0 clears it.
  - F0000018 SDATA, RO, debounced switches.
  - F0000020 TCNT, R/W.
  - F0000024 TLIM, R/W. A write also clears TCNT.
  - F0000028 TCTL, bit0 = wrap ready (sticky). Writing bit0=0 clears it.
- Unmapped I/O addresses read 0; writes to them are ignored. Unused high bits of a register read 0.
- Writes to read-only registers are ignored.
- Stores commit on the rising clk edge where wrtEn=1. Loads are combinational.
- Input path: key and sw each pass through a 2-flop synchronizer, then a debouncer (one counter per group).
  - Synced value equal to stable value: counter is held at 0.
  - Synced value differs: counter increments.
  - Counter reaches DEBOUNCE_CYCLES-1 while still differing: stable takes the synced value and the counter goes to 0.
  - Any change of the stable key vector sets KCTRL.ready.
- Timer: while lock=1, TCNT increments every cycle.
  - If TLIM!=0 and TCNT==TLIM-1, TCNT goes to 0 and TCTL.ready is set.
  - TLIM==0 means free-run with 32-bit wrap and no ready event.
- Simultaneous events:
  - CPU write to TCNT or TLIM beats the timer increment or wrap.
  - A hardware set of a ready bit beats a CPU clear in the same cycle, so no event is lost.

## Timing
- Load latency is 0 cycles (same-cycle read). Stores are visible to a load in the next cycle.
- Key/switch latency is 2 sync cycles plus DEBOUNCE_CYCLES from an input edge to the new KDATA/SDATA value. KCTRL.ready sets in the same edge as KDATA updates.
- Reset values: ledr=0, hex=0, TCNT=0, TLIM=0, both ready bits 0, debounced values 0, debounce counters 0, synchronizers 0.
- RAM contents are not reset; they come from MEM_INIT or are X.
- Reset asserted mid-debounce or mid-count abandons progress. The first count after reset release happens on the following edge.
- lock low: the timer holds its value. CPU writes still take effect, since the write enable is already qualified upstream.

## Structure
- A shared package holds the I/O address constants, the KCTRL/TCTL bit indices and the I/O region tag 4'hF.
- One sub-module, io_debounce, parameterized by WIDTH and DEBOUNCE_CYCLES (synchronizer plus counter), instanced for key and sw.
- The RAM is an inferred array inside this block.

## Test plan
- Store 0x12345678 to 0x00000100, then load 0x00000100 → 0x12345678. A load from 0x00000100 + 4·MEM_WORDS aliases to the same word.
- Write 0x3FF to LEDR and 0xBEEF to HEX → ledr=0x3FF, hex=0xBEEF. Assert reset for 1 cycle → both 0.
- With DEBOUNCE_CYCLES=10, set key=4'b0001 for 5 cycles then 0 → KDATA stays 0. Hold it → KDATA=1 and KCTRL=1 at cycle 12. Write 0 to KCTRL → reads 0.
- Write TLIM=5 → TCNT reads 0,1,2,3,4,0 and TCTL=1 after the wrap. Drop lock → TCNT holds.
- Write TCTL=0 in the same cycle as a wrap → TCTL still reads 1. Write TCNT=100 in the same cycle as an increment → reads 100.
- Load F0000030 → 0. Store to KDATA → KDATA unchanged.
